mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Multi-cycle shift-add multiplier sequencer that drives the shared 32-bit ALU and Shifter.
//  It accepts one unsigned multiply request, then alternates ALU add steps with Shifter
//  shift-left-by-1 steps, one bit of the multiplier per iteration.
//  It returns the low WIDTH bits of the product. Sits beside the ALU/Shifter pair, which it
//  controls exclusively while busy.
// PARAMETERS
//  WIDTH       32  operand/result width; must equal the ALU and Shifter width
//  EARLY_EXIT  1   1: stop once the remaining multiplier bits are all zero; 0: always WIDTH iterations
// PORTS
//  clk             in   1      clock, all state updates on rising edge
//  rst             in   1      synchronous, active-high reset
//  start           in   1      request strobe, sampled only in IDLE
//  op_a            in   WIDTH  multiplicand, sampled with start
//  op_b            in   WIDTH  multiplier, sampled with start
//  busy            out  1      high in ADD and SHIFT states
//  done            out  1      one-cycle pulse when result is updated
//  result          out  WIDTH  low WIDTH bits of op_a*op_b, held until the next done
//  result_zero     out  1      result == 0, registered with result
//  alu_src1        out  WIDTH  ALU operand 1 (partial product)
//  alu_src2        out  WIDTH  ALU operand 2 (shifted multiplicand)
//  alu_invertA     out  1      always 0
//  alu_invertB     out  1      always 0
//  alu_operation   out  2      2'b10 (ADD) at all times
//  alu_result      in   WIDTH  ALU result, combinational from alu_* outputs
//  sft_leftRight   out  1      0 = shift left; driven 0 at all times
//  sft_shamt       out  5      1 in SHIFT state, 0 otherwise
//  sft_src         out  WIDTH  multiplicand register
//  sft_result      in   WIDTH  Shifter result, combinational from sft_* outputs
// BEHAVIOUR
//  Registers: mcand, mplier, prod (WIDTH); cnt (log2(WIDTH)+1 bits); state; result; result_zero.
//  Reset: state=IDLE; mcand, mplier, prod, cnt, result=0; result_zero=1; done=0; busy=0.
//  alu_src1=prod and alu_src2=mcand are driven continuously.
//  IDLE: if start, then latch mcand=op_a, mplier=op_b, prod=0, cnt=0; next state ADD.
//    Otherwise stay in IDLE.
//  ADD: if mplier[0], then prod <= alu_result (mod 2^WIDTH; carry and ALU overflow are ignored).
//    Next state SHIFT.
//  SHIFT: mcand <= sft_result; mplier <= mplier>>1 (internal logical shift); cnt <= cnt+1.
//    Go to DONE if cnt==WIDTH-1, or if EARLY_EXIT and (mplier>>1)==0. Otherwise go to ADD.
//  DONE: result <= prod, result_zero <= (prod==0), done=1 for this cycle only; next state IDLE.
//  done is a Moore output of the DONE state; the new result is visible in the same cycle done is high.
//  Latency: with N iterations, done is high in the cycle 2N+1 clocks after the edge that sampled start.
//    N = WIDTH when EARLY_EXIT=0.
//    N = index of the highest set bit of op_b, plus 1, when EARLY_EXIT=1 (N=1 when op_b==0).
//  start while busy or in DONE is ignored and not queued. The next request is accepted in the
//    first IDLE cycle after DONE.
//  op_a/op_b are don't-care except on the accepting edge.
//  rst mid-operation aborts: everything returns to its reset value on the next edge; no done pulse.
//  rst and start together: rst wins, request dropped.
//  Shifter bits shifted out of mcand are discarded (wrap-around modulo 2^WIDTH).
// TESTING
//  1. Reset, idle: rst=1 for 2 cycles -> busy=0, done=0, result=0, result_zero=1, alu_operation=2'b10, sft_shamt=0.
//  2. EARLY_EXIT=1, op_a=7, op_b=5 -> N=3; done 7 clocks after accept; result=35, result_zero=0.
//  3. EARLY_EXIT=1, op_a=0x1234, op_b=0 -> N=1; done 3 clocks after accept; result=0, result_zero=1.
//  4. EARLY_EXIT=0, op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> done 65 clocks after accept; result=0x00000001.
//  5. EARLY_EXIT=1, op_a=0x00010000, op_b=0x00010000 -> result=0 (wrap), result_zero=1.
//     Then a second start pulsed while busy -> ignored; only one done pulse is seen.
//  6. Start op_a=3, op_b=0x80000000; assert rst 10 clocks later -> no done, busy=0, result=0.
//     Then op_a=6, op_b=7 -> result=42.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Shift-add multiplier sequencer. Drives the shared ALU (always ADD) and the
// Shifter (left by 1 in SHIFT) to form the low WIDTH bits of op_a * op_b, one
// multiplier bit per ADD/SHIFT pair.
module mul_seq_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_zero,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic             alu_invertA,
    output logic             alu_invertB,
    output logic [1:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    output logic             sft_leftRight,
    output logic [4:0]       sft_shamt,
    output logic [WIDTH-1:0] sft_src,
    input  logic [WIDTH-1:0] sft_result
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAdd   = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_zero_q, result_zero_d;
    logic             last_iter;

    // Final iteration: all bits consumed, or (optionally) no set bits remain.
    assign last_iter = (cnt_q == CntW'(WIDTH - 1)) ||
                       (EARLY_EXIT && ((mplier_q >> 1) == '0));

    // Next-state and datapath register updates.
    always_comb begin
        state_d       = state_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        prod_d        = prod_q;
        cnt_d         = cnt_q;
        result_d      = result_q;
        result_zero_d = result_zero_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = StAdd;
                end
            end
            StAdd: begin
                if (mplier_q[0]) begin
                    prod_d = alu_result;
                end
                state_d = StShift;
            end
            StShift: begin
                mcand_d  = sft_result;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (last_iter) begin
                    // Publish on entry to DONE so result is valid alongside done.
                    result_d      = prod_q;
                    result_zero_d = (prod_q == '0);
                    state_d       = StDone;
                end else begin
                    state_d = StAdd;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            mcand_q       <= '0;
            mplier_q      <= '0;
            prod_q        <= '0;
            cnt_q         <= '0;
            result_q      <= '0;
            result_zero_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            prod_q        <= prod_d;
            cnt_q         <= cnt_d;
            result_q      <= result_d;
            result_zero_q <= result_zero_d;
        end
    end

    // Moore outputs and fixed ALU/Shifter controls.
    always_comb begin
        busy          = (state_q == StAdd) || (state_q == StShift);
        done          = (state_q == StDone);
        result        = result_q;
        result_zero   = result_zero_q;
        alu_src1      = prod_q;
        alu_src2      = mcand_q;
        alu_invertA   = 1'b0;
        alu_invertB   = 1'b0;
        alu_operation = 2'b10;
        sft_leftRight = 1'b0;
        sft_shamt     = (state_q == StShift) ? 5'd1 : 5'd0;
        sft_src       = mcand_q;
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: two instances (EARLY_EXIT=1 and 0) share stimulus,
// each with its own ALU/Shifter model and a transaction-level reference model.
module tb_mul_seq_ctrl;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;

    logic         busy [2];
    logic         done [2];
    logic [W-1:0] result [2];
    logic         result_zero [2];
    logic [W-1:0] alu_src1 [2];
    logic [W-1:0] alu_src2 [2];
    logic         alu_inv_a [2];
    logic         alu_inv_b [2];
    logic [1:0]   alu_op [2];
    logic [W-1:0] alu_res [2];
    logic         sft_lr [2];
    logic [4:0]   sft_shamt [2];
    logic [W-1:0] sft_src [2];
    logic [W-1:0] sft_res [2];

    // External ALU and Shifter behaviour.
    for (genvar g = 0; g < 2; g++) begin : g_ext
        logic [W-1:0] a_in, b_in;
        assign a_in = alu_inv_a[g] ? ~alu_src1[g] : alu_src1[g];
        assign b_in = alu_inv_b[g] ? ~alu_src2[g] : alu_src2[g];
        assign alu_res[g] = (alu_op[g] == 2'b10) ? a_in + b_in : '0;
        assign sft_res[g] = sft_lr[g] ? (sft_src[g] >> sft_shamt[g])
                                      : (sft_src[g] << sft_shamt[g]);
    end

    mul_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy[0]), .done(done[0]), .result(result[0]), .result_zero(result_zero[0]),
        .alu_src1(alu_src1[0]), .alu_src2(alu_src2[0]), .alu_invertA(alu_inv_a[0]),
        .alu_invertB(alu_inv_b[0]), .alu_operation(alu_op[0]), .alu_result(alu_res[0]),
        .sft_leftRight(sft_lr[0]), .sft_shamt(sft_shamt[0]), .sft_src(sft_src[0]),
        .sft_result(sft_res[0])
    );

    mul_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_full (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy[1]), .done(done[1]), .result(result[1]), .result_zero(result_zero[1]),
        .alu_src1(alu_src1[1]), .alu_src2(alu_src2[1]), .alu_invertA(alu_inv_a[1]),
        .alu_invertB(alu_inv_b[1]), .alu_operation(alu_op[1]), .alu_result(alu_res[1]),
        .sft_leftRight(sft_lr[1]), .sft_shamt(sft_shamt[1]), .sft_src(sft_src[1]),
        .sft_result(sft_res[1])
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: per instance, the edge index that accepted the current
    // request, the edge index after which done is high, and the product.
    int           t = 0;
    bit           pend [2];
    int           acc_e [2];
    int           done_e [2];
    logic [W-1:0] pres [2];
    logic [W-1:0] res [2];

    function automatic int iters(input logic [W-1:0] b, input int inst);
        if (inst == 1) return W;
        if (b == '0) return 1;
        for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 1;
        return 1;
    endfunction

    // Instance is in IDLE before edge e (so a start at edge e is accepted).
    function automatic bit idle_at(input int inst, input int e);
        return !pend[inst] || (e >= done_e[inst] + 2);
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            bit exp_busy, exp_done;
            exp_busy = pend[i] && (t >= acc_e[i]) && (t < done_e[i]);
            exp_done = pend[i] && (t == done_e[i]);
            chk($sformatf("u%0d busy t=%0d", i, t), W'(busy[i]), W'(exp_busy));
            chk($sformatf("u%0d done t=%0d", i, t), W'(done[i]), W'(exp_done));
            chk($sformatf("u%0d result t=%0d", i, t), result[i], res[i]);
            chk($sformatf("u%0d result_zero t=%0d", i, t), W'(result_zero[i]),
                W'(res[i] == '0));
            chk($sformatf("u%0d sft_shamt t=%0d", i, t), W'(sft_shamt[i]),
                W'((exp_busy && ((t - acc_e[i]) % 2 == 1)) ? 1 : 0));
            chk($sformatf("u%0d alu_operation t=%0d", i, t), W'(alu_op[i]), W'(2'b10));
            chk($sformatf("u%0d fixed ctrl t=%0d", i, t),
                W'({alu_inv_a[i], alu_inv_b[i], sft_lr[i]}), W'(0));
            if (exp_done) chk($sformatf("u%0d alu_src1 at done", i), alu_src1[i], res[i]);
        end
    endtask

    // One clock: advance the model on the edge, then compare just after it.
    task automatic tick();
        @(posedge clk);
        t++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                pend[i] = 1'b0;
                res[i]  = '0;
            end else if (start && idle_at(i, t)) begin
                pend[i]   = 1'b1;
                acc_e[i]  = t;
                done_e[i] = t + 2 * iters(op_b, i);
                pres[i]   = op_a * op_b;
            end
            if (pend[i] && t == done_e[i]) res[i] = pres[i];
        end
        #1;
        check_all();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            if (idle_at(0, t + 1) && idle_at(1, t + 1)) return;
            tick();
        end
        chk("wait_idle timeout", 32'd1, 32'd0);
    endtask

    // Issue one request; lat counts cycles from the one opened by the accept
    // edge (that cycle = 1) to the cycle where done of instance inst is high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inst,
                          input int exp_lat, input logic [W-1:0] exp_res,
                          input string name);
        int lat;
        lat = 0;
        start = 1'b1; op_a = a; op_b = b;
        tick();
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        for (int k = 1; k < 200; k++) begin
            tick();
            if (done[inst]) begin
                lat = k + 1;
                break;
            end
        end
        chk({name, " latency"}, W'(lat), W'(exp_lat));
        chk({name, " result"}, result[inst], exp_res);
        chk({name, " result_zero"}, W'(result_zero[inst]), W'(exp_res == '0));
        wait_idle();
    endtask

    initial begin
        int ndone;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; acc_e[i] = 0; done_e[i] = -10; pres[i] = '0; res[i] = '0;
        end

        // Reset and idle outputs.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("reset busy", W'(busy[i]), 0);
            chk("reset done", W'(done[i]), 0);
            chk("reset result", result[i], 0);
            chk("reset result_zero", W'(result_zero[i]), 1);
            chk("reset alu_operation", W'(alu_op[i]), 2);
            chk("reset sft_shamt", W'(sft_shamt[i]), 0);
        end

        run_op(32'd7, 32'd5, 0, 7, 32'd35, "ee 7*5");
        run_op(32'h1234, 32'd0, 0, 3, 32'd0, "ee 0x1234*0");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 65, 32'd1, "full ffff*ffff");
        run_op(32'd7, 32'd5, 1, 65, 32'd35, "full 7*5");

        // Wrapping product plus a start pulse while busy that must be dropped.
        ndone = 0;
        start = 1'b1; op_a = 32'h0001_0000; op_b = 32'h0001_0000;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        tick();
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done[0]) ndone++;
        end
        chk("wrap done count", W'(ndone), 1);
        chk("wrap result", result[0], 0);
        chk("wrap result_zero", W'(result_zero[0]), 1);
        wait_idle();

        // Reset mid-operation aborts without a done pulse.
        start = 1'b1; op_a = 32'd3; op_b = 32'h8000_0000;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("abort busy", W'(busy[i]), 0);
            chk("abort done", W'(done[i]), 0);
            chk("abort result", result[i], 0);
        end
        run_op(32'd6, 32'd7, 0, 7, 32'd42, "ee 6*7 after abort");

        // rst and start together: request dropped.
        rst = 1'b1; start = 1'b1; op_a = 32'd5; op_b = 32'd5;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        chk("rst+start busy", W'(busy[0]), 0);
        chk("rst+start busy full", W'(busy[1]), 0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 2500; k++) begin
            start = ($urandom_range(0, 3) == 0);
            op_a  = $urandom;
            op_b  = $urandom >> $urandom_range(0, 31);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
